mem_master: RTL

Initiator for the `mem_if` memory interface: accepts read/write commands on a valid/ready port, drives `wr`/`rd`/`addr`/`data` toward the memory responder and collects `rddata` on `rddatavalid`. Read data is buffered in a small response FIFO with credit-based issue, so the block never drops a read response and never stalls the memory.

---
 rtl/mem_master_pkg.sv | 20 ++
 rtl/mem_if.sv | 22 ++
 rtl/mem_master_fifo.sv | 57 +++++
 rtl/mem_master.sv | 126 ++++++++++++
 4 files changed

// File: rtl/mem_master_pkg.sv
// ---------------------------------------------------------------------------
// mem_master_pkg : shared command type and default widths for mem_master
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_master_pkg;

  localparam int MM_DWIDTH = 8;
  localparam int MM_AWIDTH = 6;

  typedef struct packed {
    logic                 wr;
    logic [MM_AWIDTH-1:0] addr;
    logic [MM_DWIDTH-1:0] data;
  } cmd_t;

endpackage

`default_nettype wire

// File: rtl/mem_if.sv
// ---------------------------------------------------------------------------
// mem_if : simple memory bus between an initiator and a memory responder
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mem_if #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 6
);
  logic              wr;
  logic              rd;
  logic [AWIDTH-1:0] addr;
  logic [DWIDTH-1:0] data;
  logic [DWIDTH-1:0] rddata;
  logic              rddatavalid;

  modport master (output wr, rd, addr, data, input rddata, rddatavalid);
  modport slave  (input wr, rd, addr, data, output rddata, rddatavalid);
endinterface

`default_nettype wire

// File: rtl/mem_master_fifo.sv
// ---------------------------------------------------------------------------
// mem_master_fifo : synchronous show-ahead FIFO with occupancy count
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_master_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_do_pop;

  assign w_do_pop = pop && (r_count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (push)     r_wptr <= r_wptr + 1'b1;
      if (w_do_pop) r_rptr <= r_rptr + 1'b1;
      case ({push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wptr] <= wdata;
  end

  assign rdata = (r_count != '0) ? r_mem[r_rptr] : '0;
  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/mem_master.sv
// ---------------------------------------------------------------------------
// mem_master : mem_if initiator with credit-based response FIFO.
//              Optional response timeout/error checking: MEM_MASTER_TIMEOUT_EN
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_master
  import mem_master_pkg::*;
#(
  parameter int DWIDTH    = MM_DWIDTH,
  parameter int AWIDTH    = MM_AWIDTH,
  parameter int RSP_DEPTH = 4,
  parameter int TIMEOUT   = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_wr_i,
  input  logic [AWIDTH-1:0] cmd_addr_i,
  input  logic [DWIDTH-1:0] cmd_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DWIDTH-1:0] rsp_data_o,
  output logic              err_o,
  mem_if.master             mem
);

  localparam int CW = $clog2(RSP_DEPTH+1);

  logic              r_wr;
  logic              r_rd;
  logic [AWIDTH-1:0] r_addr;
  logic [DWIDTH-1:0] r_data;
  logic [CW-1:0]     r_inflight;
  logic [CW-1:0]     w_fifo_count;
  logic [CW:0]       w_credit;
  logic              w_accept;
  logic              w_acc_rd;
  logic              w_capture;

  // Every outstanding read owns a FIFO slot, so captures can never overflow.
  assign w_credit    = {1'b0, w_fifo_count} + {1'b0, r_inflight};
  assign cmd_ready_o = !rst_i && (w_credit < (CW+1)'(RSP_DEPTH));
  assign w_accept    = cmd_valid_i && cmd_ready_o;
  assign w_acc_rd    = w_accept && !cmd_wr_i;
  assign w_capture   = mem.rddatavalid && (r_inflight != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr   <= 1'b0;
      r_rd   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_wr <= w_accept && cmd_wr_i;
      r_rd <= w_acc_rd;
      if (w_accept)             r_addr <= cmd_addr_i;
      if (w_accept && cmd_wr_i) r_data <= cmd_data_i;
    end
  end

  assign mem.wr   = r_wr;
  assign mem.rd   = r_rd;
  assign mem.addr = r_addr;
  assign mem.data = r_data;

`ifdef MEM_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT+1);

  logic [TW-1:0] r_tmo;
  logic          r_err;
  logic          w_expire;

  assign w_expire = (r_inflight != '0) && !w_capture && (r_tmo == TW'(TIMEOUT-1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_inflight <= '0;
      r_tmo      <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_expire) begin
        r_inflight <= CW'(w_acc_rd);
        r_tmo      <= '0;
        r_err      <= 1'b1;
      end else begin
        r_inflight <= r_inflight + CW'(w_acc_rd) - CW'(w_capture);
        if ((r_inflight == '0) || w_capture) r_tmo <= '0;
        else                                 r_tmo <= r_tmo + 1'b1;
      end
      if (mem.rddatavalid && (r_inflight == '0)) r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  localparam int UNUSED_TIMEOUT = TIMEOUT;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_inflight <= '0;
    else       r_inflight <= r_inflight + CW'(w_acc_rd) - CW'(w_capture);
  end

  assign err_o = 1'b0;
`endif

  mem_master_fifo #(
    .WIDTH (DWIDTH),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (w_capture),
    .pop   (rsp_ready_i),
    .wdata (mem.rddata),
    .rdata (rsp_data_o),
    .count (w_fifo_count)
  );

  assign rsp_valid_o = (w_fifo_count != '0);

endmodule

`default_nettype wire
